// File: rtl/calc_frame_tx.sv
// calc_frame_tx: serialises num1/num2/op frames onto a 12-bit tagged bus, then waits for a result or times out.
// First frame follows acceptance by one cycle; req_ready only in IDLE; CALC_TX_SKIP_EN enables operand-frame skipping.
module calc_frame_tx #(
  parameter int GAP_CYCLES   = 1,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_num1,
  input  logic [9:0]  req_num2,
  input  logic [3:0]  req_op,
  output logic [11:0] out,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_timeout
);
  typedef enum logic [2:0] {IDLE, N1, N2, OP, GAP, WAIT} state_t;

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RESP_TIMEOUT - 1);

  state_t     state;
  logic [9:0] num1_r;
  logic [9:0] num2_r;
  logic [3:0] op_r;
  logic [3:0] gap_cnt;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       skip1;
  logic       skip2_req;
  logic       skip2_n1;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef CALC_TX_SKIP_EN
  logic [9:0] cache_num1;
  logic [9:0] cache_num2;
  logic       cache_vld;

  assign skip1     = cache_vld && (req_num1 == cache_num1);
  assign skip2_req = cache_vld && (req_num2 == cache_num2);
  assign skip2_n1  = cache_vld && (num2_r == cache_num2);

  // Cache tracks what the far end last saw; a timeout means it may have lost it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cache_num1 <= '0;
      cache_num2 <= '0;
      cache_vld  <= 1'b0;
    end else begin
      if (state == N1) cache_num1 <= num1_r;
      if (state == N2) cache_num2 <= num2_r;
      if (state == OP)
        cache_vld <= 1'b1;
      else if (state == WAIT && !res_valid && wait_cnt == WAIT_LAST)
        cache_vld <= 1'b0;
    end
  end
`else
  assign skip1     = 1'b0;
  assign skip2_req = 1'b0;
  assign skip2_n1  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      out          <= '0;
      num1_r       <= '0;
      num2_r       <= '0;
      op_r         <= '0;
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          out <= '0;
          if (accept) begin
            num1_r <= req_num1;
            num2_r <= req_num2;
            op_r   <= req_op;
            if (!skip1) begin
              state <= N1;
              out   <= {req_num1, 2'b01};
            end else if (!skip2_req) begin
              state <= N2;
              out   <= {req_num2, 2'b10};
            end else begin
              state <= OP;
              out   <= {6'b0, req_op, 2'b11};
            end
          end
        end
        N1: begin
          if (skip2_n1) begin
            state <= OP;
            out   <= {6'b0, op_r, 2'b11};
          end else begin
            state <= N2;
            out   <= {num2_r, 2'b10};
          end
        end
        N2: begin
          state <= OP;
          out   <= {6'b0, op_r, 2'b11};
        end
        OP: begin
          state   <= GAP;
          out     <= '0;
          gap_cnt <= '0;
        end
        GAP: begin
          out <= '0;
          if (gap_cnt == GAP_LAST) begin
            state    <= WAIT;
            gap_cnt  <= '0;
            wait_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        WAIT: begin
          out <= '0;
          // A result on the last allowed cycle still wins over the timeout.
          if (res_valid) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            resp_valid   <= 1'b1;
            resp_data    <= res_data;
            resp_timeout <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            resp_valid   <= 1'b1;
            resp_data    <= '0;
            resp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_frame_tx.sv
// Bench for calc_frame_tx: directed and randomised transactions against a frame-list/response-time reference model.
module tb_calc_frame_tx;
  localparam int GAP = 2;
  localparam int TO  = 64;
`ifdef CALC_TX_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_num1;
  logic [9:0]  req_num2;
  logic [3:0]  req_op;
  logic [11:0] out;
  logic        res_valid;
  logic [15:0] res_data;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_timeout;

  calc_frame_tx #(.GAP_CYCLES(GAP), .RESP_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num1(req_num1), .req_num2(req_num2), .req_op(req_op),
    .out(out),
    .res_valid(res_valid), .res_data(res_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what the far end is believed to hold, and frame spacing.
  bit          m_vld = 1'b0;
  logic [9:0]  m_n1  = '0;
  logic [9:0]  m_n2  = '0;
  int          zero_run = 0;
  bit          seen_op  = 1'b0;
  logic [15:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic track(input logic [11:0] f);
    if (f[1:0] == 2'b11) begin
      seen_op  = 1'b1;
      zero_run = 0;
    end else if (f == 12'h000) begin
      zero_run++;
    end else if (f[1:0] == 2'b01 && seen_op) begin
      chk("gap_before_num1", 32'(zero_run >= GAP), 32'd1);
      seen_op = 1'b0;
    end
  endtask

  // res_at: WAIT-cycle index carrying res_valid, or -1 for none. spur: frame index (1-based)
  // carrying a spurious res_valid, 0 for none, 99 for the op frame.
  task automatic do_txn(input logic [9:0] n1, input logic [9:0] n2, input logic [3:0] op,
                        input int res_at, input logic [15:0] rdata, input int spur,
                        input bit keep, input logic [9:0] k1, input logic [9:0] k2, input logic [3:0] kop);
    logic [11:0] fr[$];
    logic [11:0] exp_out;
    int w0, r, sp;
    fr = {};
    if (!(SKIP_EN && m_vld && n1 == m_n1)) fr.push_back(12'(n1) * 12'd4 + 12'd1);
    if (!(SKIP_EN && m_vld && n2 == m_n2)) fr.push_back(12'(n2) * 12'd4 + 12'd2);
    fr.push_back(12'(op) * 12'd4 + 12'd3);
    sp = (spur == 99) ? fr.size() : spur;
    w0 = fr.size() + GAP + 1;
    r  = (res_at >= 0) ? (w0 + res_at + 1) : (w0 + TO);

    req_num1  = n1;
    req_num2  = n2;
    req_op    = op;
    req_valid = 1'b1;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    for (int i = 1; i <= r; i++) begin
      exp_out = (i <= fr.size()) ? fr[i-1] : 12'h000;
      chk("out_frame", 32'(out), 32'(exp_out));
      track(out);
      chk("req_ready", 32'(req_ready), 32'(i == r));
      chk("resp_valid", 32'(resp_valid), 32'(i == r));
      if (i == r) begin
        chk("resp_timeout", 32'(resp_timeout), 32'(res_at < 0));
        chk("resp_data", 32'(resp_data), (res_at < 0) ? 32'd0 : 32'(rdata));
      end
      if (i == 1) begin
        if (keep) begin
          req_num1 = k1;
          req_num2 = k2;
          req_op   = kop;
        end else begin
          req_valid = 1'b0;
        end
      end
      res_valid = (i == sp) || (res_at >= 0 && i == w0 + res_at);
      res_data  = res_valid ? rdata : 16'(($urandom));
      if (i < r) @(negedge clock);
    end
    res_valid = 1'b0;
    m_n1 = n1;
    m_n2 = n2;
    m_vld = (res_at >= 0);
    last_data = (res_at >= 0) ? rdata : 16'h0000;
  endtask

  initial begin
    logic [9:0] a1, a2;
    logic [3:0] aop;
    int ra;
    reset_n = 1'b0; req_valid = 1'b0; req_num1 = '0; req_num2 = '0; req_op = '0;
    res_valid = 1'b0; res_data = '0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    @(negedge clock); @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Basic transaction: frames 0x015, 0x00E, 0x00B, result 0x0008.
    do_txn(10'd5, 10'd3, 4'd2, 4, 16'h0008, 0, 1'b0, '0, '0, '0);
    @(negedge clock);
    chk("resp_valid_pulse_end", 32'(resp_valid), 32'd0);
    chk("resp_data_held", 32'(resp_data), 32'h0008);
    chk("resp_timeout_held", 32'(resp_timeout), 32'd0);

    // Spurious res_valid during N1, then during the op frame.
    do_txn(10'(($urandom)), 10'(($urandom)), 4'(($urandom)), $urandom_range(0, 10), 16'(($urandom)), 1, 1'b0, '0, '0, '0);
    do_txn(10'(($urandom)), 10'(($urandom)), 4'(($urandom)), $urandom_range(0, 10), 16'(($urandom)), 99, 1'b0, '0, '0, '0);

    // Result on the last allowed WAIT cycle is a capture.
    do_txn(10'(($urandom)), 10'(($urandom)), 4'(($urandom)), TO - 1, 16'(($urandom)), 0, 1'b0, '0, '0, '0);

    // Back-to-back with req_valid held high.
    a1 = 10'(($urandom)); a2 = 10'(($urandom)); aop = 4'(($urandom));
    do_txn(10'(($urandom)), 10'(($urandom)), 4'(($urandom)), 2, 16'(($urandom)), 0, 1'b1, a1, a2, aop);
    do_txn(a1, a2, aop, 0, 16'(($urandom)), 0, 1'b0, '0, '0, '0);

    // Operand reuse, then timeout, then the same request again.
    do_txn(10'd7, 10'd9, 4'd1, 3, 16'h1234, 0, 1'b0, '0, '0, '0);
    do_txn(10'd7, 10'd9, 4'd1, 5, 16'h5678, 0, 1'b0, '0, '0, '0);
    do_txn(10'd7, 10'd9, 4'd1, -1, 16'h0000, 0, 1'b0, '0, '0, '0);
    @(negedge clock);
    chk("to_data_held", 32'(resp_data), 32'd0);
    chk("to_flag_held", 32'(resp_timeout), 32'd1);
    do_txn(10'd7, 10'd9, 4'd1, 1, 16'h9abc, 0, 1'b0, '0, '0, '0);

    // Reset during the N2 frame (previous timeout leaves no cached operands).
    do_txn(10'd7, 10'd9, 4'd3, -1, 16'h0000, 0, 1'b0, '0, '0, '0);
    a1 = 10'(($urandom)); a2 = 10'(($urandom));
    req_num1 = a1; req_num2 = a2; req_op = 4'(($urandom)); req_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    chk("mid_n1", 32'(out), 32'(12'(a1) * 12'd4 + 12'd1));
    @(negedge clock);
    chk("mid_n2", 32'(out), 32'(12'(a2) * 12'd4 + 12'd2));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    #2 reset_n = 1'b1;
    m_vld = 1'b0; seen_op = 1'b0; zero_run = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("post_rst_out", 32'(out), 32'd0);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
    end
    chk("post_rst_resp_data", 32'(resp_data), 32'd0);

    // Randomised transactions, occasionally reusing operands or timing out.
    a1 = 10'(($urandom)); a2 = 10'(($urandom));
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 2) != 0) begin a1 = 10'(($urandom)); end
      if ($urandom_range(0, 2) != 0) begin a2 = 10'(($urandom)); end
      ra = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_txn(a1, a2, 4'(($urandom)), ra, 16'(($urandom)), int'($urandom_range(0, 3)), 1'b0, '0, '0, '0);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) @(negedge clock);
      chk("idle_hold_data", 32'(resp_data), 32'(last_data));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_frame_tx.md
CALC_FRAME_TX -- requirements
Module: calc_frame_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1: idle (all-zero) frames driven after each op frame; legal range 1..15.
REQ-002 SHALL have parameter RESP_TIMEOUT, default 64: maximum cycles spent waiting for a result; legal range 2..255.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: a transaction request is presented.
REQ-006 SHALL have port req_ready, output, 1: the block can accept a request.
REQ-007 SHALL have port req_num1, input, 10: first operand.
REQ-008 SHALL have port req_num2, input, 10: second operand.
REQ-009 SHALL have port req_op, input, 4: opcode.
REQ-010 SHALL have port out, output, 12: frame bus; out[1:0] is the tag (00 idle, 01 num1, 10 num2, 11 op), out[11:2] is the payload.
REQ-011 SHALL have port res_valid, input, 1: the calculator result is valid this cycle.
REQ-012 SHALL have port res_data, input, 16: the calculator result.
REQ-013 SHALL have port resp_valid, output, 1: one-cycle response pulse.
REQ-014 SHALL have port resp_data, output, 16: returned result.
REQ-015 SHALL have port resp_timeout, output, 1: qualifies resp_valid; 1 means no result arrived.

Function
REQ-016 SHALL implement FSM states IDLE, N1, N2, OP, GAP, WAIT.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and the operands and opcode are registered at that edge.
REQ-018 SHALL drive out as registered values: {num1,01} in N1, {num2,10} in N2, {6'b0,op,11} in OP, and 12'h000 in every other state.
REQ-019 SHALL follow the sequence acceptance -> N1 -> N2 -> OP, one cycle each, so the first frame appears the cycle after acceptance.
REQ-020 SHALL hold GAP for exactly GAP_CYCLES cycles, then enter WAIT.
REQ-021 SHALL, in WAIT, count cycles from 0; on res_valid=1 it captures res_data and returns to IDLE.
REQ-022 SHALL, in WAIT, leave after RESP_TIMEOUT cycles without res_valid by setting resp_timeout=1 and resp_data=0, then return to IDLE.
REQ-023 SHALL pulse resp_valid for exactly one cycle, the cycle after capture or timeout, together with resp_data and resp_timeout; both hold their values until the next response.
REQ-024 SHALL ignore res_valid outside WAIT, including a res_valid in the same cycle as the OP frame.
REQ-025 SHALL accept a new request in the cycle resp_valid is high, because the FSM is already in IDLE by then.
REQ-026 SHALL treat res_valid on the final timeout cycle as a capture, not a timeout.
REQ-027 SHALL never place two non-idle frames around an op frame without at least one 12'h000 frame between the op frame and the next num1 frame.

Reset
REQ-028 SHALL, while reset_n=0, set the state to IDLE, out=0, req_ready=1 once released, resp_valid=0, resp_data=0, resp_timeout=0, the counters to 0, and invalidate the operand cache.
REQ-029 SHALL, when reset is asserted in the middle of a frame sequence, abort the sequence immediately with out=0 and produce no response.

Configuration
REQ-030 SHALL support macro CALC_TX_SKIP_EN: when defined, the block caches the last num1 and num2 it sent, with a valid bit; the N1 or N2 frame is skipped when the cache is valid and the operand is equal; the op frame is always sent; a timeout invalidates the cache.
REQ-031 SHALL, when CALC_TX_SKIP_EN is undefined, always send all three frames and contain no cache logic.

Verification
REQ-032 SHALL cover the basic transaction: req num1=5, num2=3, op=2 with res_valid after 4 cycles and res_data=16'h0008 -> frames 0x015, 0x00E, 0x00B, then 0x000; resp_valid for 1 cycle with data 0x0008 and resp_timeout=0.
REQ-033 SHALL cover timeout: a request with res_valid never asserted and RESP_TIMEOUT=64 -> resp_valid with resp_timeout=1 and resp_data=0 exactly 64 cycles after WAIT entry.
REQ-034 SHALL cover back-to-back requests: req_valid held high with two requests -> the second is accepted in the resp_valid cycle, and at least GAP_CYCLES zero frames separate the op frame from the next num1 frame.
REQ-035 SHALL cover reset mid-sequence: reset_n pulled low during the N2 frame -> out=0 asynchronously, no resp_valid, req_ready=1 after release.
REQ-036 SHALL cover the skip feature, with CALC_TX_SKIP_EN defined: two requests with num1=7 and num2=9, then 9 -> the second transaction emits only the op frame; after a timeout, the same request emits all three frames.
REQ-037 SHALL cover a spurious result: res_valid=1 during N1 -> ignored, and the later real res_valid is captured.
